// File: rtl/sobel_pkg.sv
// Shared widths, datapath types and the saturation helper for the Sobel window calculator.
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [MAG_W-1:0]         mag_t;

    // Window indexed [row][col]: row 0 = top, col 2 = newest column.
    typedef pix_t [2:0][2:0] window_t;

    // Per-stage tag travelling alongside the datapath.
    typedef struct packed {
        logic valid;
        logic eol;
        logic eof;
    } tag_t;

    function automatic pix_t sat8(input mag_t mag);
        return (mag > mag_t'(255)) ? pix_t'(8'hFF) : mag[PIX_W-1:0];
    endfunction

    function automatic mag_t abs_grad(input grad_t g);
        grad_t neg;
        neg = -g;
        return g[GRAD_W-1] ? mag_t'(neg) : mag_t'(g);
    endfunction

endpackage

// File: rtl/sobel_window_calc_if.sv
// Column input from the line buffer and pixel output towards the downstream FIFO.
interface sobel_window_calc_if;
    import sobel_pkg::*;

    logic we;
    pix_t pix_bot;
    pix_t pix_mid;
    pix_t pix_top;
    pix_t thresh;
    logic dout_valid;
    pix_t dout;
    logic dout_eol;
    logic dout_eof;

    // Driver side: line buffer feeding columns, consumer observing results.
    modport master (
        output we, pix_bot, pix_mid, pix_top, thresh,
        input  dout_valid, dout, dout_eol, dout_eof
    );

    // Calculator side.
    modport slave (
        input  we, pix_bot, pix_mid, pix_top, thresh,
        output dout_valid, dout, dout_eol, dout_eof
    );

endinterface

// File: rtl/sobel_kernel3x3.sv
// Combinational 3x3 Sobel kernel: nine window pixels in, signed horizontal/vertical gradients out.
module sobel_kernel3x3
    import sobel_pkg::*;
(
    input  window_t win_i,
    output grad_t   gx_o,
    output grad_t   gy_o
);

    function automatic grad_t ext(input pix_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    grad_t gx_pos, gx_neg, gy_pos, gy_neg;

    always_comb begin
        gx_pos = ext(win_i[0][2]) + (ext(win_i[1][2]) <<< 1) + ext(win_i[2][2]);
        gx_neg = ext(win_i[0][0]) + (ext(win_i[1][0]) <<< 1) + ext(win_i[2][0]);
        gy_pos = ext(win_i[2][0]) + (ext(win_i[2][1]) <<< 1) + ext(win_i[2][2]);
        gy_neg = ext(win_i[0][0]) + (ext(win_i[0][1]) <<< 1) + ext(win_i[0][2]);
        gx_o   = gx_pos - gx_neg;
        gy_o   = gy_pos - gy_neg;
    end

endmodule

// File: rtl/sobel_window_calc.sv
// Sliding 3x3 window, Sobel |Gx|+|Gy| magnitude, 4-stage pipeline (E0..E3) with line/frame markers.
// Define SOBEL_THRESH_EN to binarize the output against bus.thresh instead of emitting the magnitude.
module sobel_window_calc
    import sobel_pkg::*;
#(
    parameter int IMG_W = 1920,
    parameter int IMG_H = 1080
) (
    input  logic clk,
    input  logic rst_p,
    sobel_window_calc_if.slave bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

    // E0: window and position counters
    window_t win_q, win_d;
    col_t    col_cnt_q, col_cnt_d;
    row_t    row_cnt_q, row_cnt_d;
    tag_t    tag0_q, tag0_d;

    // E1..E3 pipeline
    grad_t gx, gy;
    grad_t gx_q, gy_q;
    tag_t  tag1_q;
    mag_t  mag_d, mag_q;
    tag_t  tag2_q;
    pix_t  dout_d, dout_q;
    logic  dout_valid_q, dout_eol_q, dout_eof_q;

    logic col_last, row_last;

    assign col_last = (col_cnt_q == col_t'(IMG_W - 1));
    assign row_last = (row_cnt_q == row_t'(IMG_H - 3));

    // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
    always_comb begin
        win_d     = win_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        tag0_d    = '0;
        if (bus.we) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = bus.pix_top;
            win_d[1][2] = bus.pix_mid;
            win_d[2][2] = bus.pix_bot;

            col_cnt_d = col_last ? '0 : col_cnt_q + col_t'(1);
            if (col_last) begin
                row_cnt_d = row_last ? '0 : row_cnt_q + row_t'(1);
            end

            tag0_d.valid = (col_cnt_q >= col_t'(2));
            tag0_d.eol   = col_last;
            tag0_d.eof   = col_last & row_last;
        end
    end

    // NOTE: the window is reset along with the counters so a mid-line reset leaves no stale columns.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            win_q     <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            tag0_q    <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
            win_q     <= win_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            tag0_q    <= tag0_d;
        end
    end

    sobel_kernel3x3 u_kernel (
        .win_i (win_q),
        .gx_o  (gx),
        .gy_o  (gy)
    );

    always_comb begin
        mag_d = abs_grad(gx_q) + abs_grad(gy_q);
    end

`ifdef SOBEL_THRESH_EN
    always_comb begin
        dout_d = (sat8(mag_q) >= bus.thresh) ? pix_t'(8'hFF) : pix_t'(8'h00);
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh;

    always_comb begin
        dout_d = sat8(mag_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_p) begin
            gx_q         <= '0;
            gy_q         <= '0;
            tag1_q       <= '0;
            mag_q        <= '0;
            tag2_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_eol_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
        end else begin
            gx_q         <= gx;
            gy_q         <= gy;
            tag1_q       <= tag0_q;
            mag_q        <= mag_d;
            tag2_q       <= tag1_q;
            if (tag2_q.valid) begin
                dout_q <= dout_d;
            end
            dout_valid_q <= tag2_q.valid;
            dout_eol_q   <= tag2_q.valid & tag2_q.eol;
            dout_eof_q   <= tag2_q.valid & tag2_q.eof;
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.dout_eol   = dout_eol_q;
    assign bus.dout_eof   = dout_eof_q;

endmodule

// File: tb/tb_sobel_window_calc.sv
// Scoreboard bench for sobel_window_calc at IMG_W=8, IMG_H=5 with hand-computed expected outputs.
module tb_sobel_window_calc;

    localparam int W = 8;
    localparam int H = 5;

    typedef logic [W-1:0][7:0]   line_t;
    typedef logic [W-3:0][7:0]   exp_line_t;

    typedef struct {
        logic [7:0] d;
        logic       eol;
        logic       eof;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_p;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   line_idx = 0;
    exp_t sb[$];

    sobel_window_calc_if bus();

    sobel_window_calc #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] map_exp(input logic [7:0] s);
`ifdef SOBEL_THRESH_EN
        return (s >= 8'd128) ? 8'hFF : 8'h00;
`else
        return s;
`endif
    endfunction

    function automatic line_t fill(input logic [7:0] v);
        line_t l;
        for (int i = 0; i < W; i++) l[i] = v;
        return l;
    endfunction

    function automatic line_t step(input logic [7:0] lo, input logic [7:0] hi);
        line_t l;
        for (int i = 0; i < W; i++) l[i] = (i < 4) ? lo : hi;
        return l;
    endfunction

    function automatic line_t imp(input int pos, input logic [7:0] v);
        line_t l;
        l = '0;
        l[pos] = v;
        return l;
    endfunction

    function automatic exp_line_t e6(input logic [7:0] a, b, c, d, e, f);
        exp_line_t x;
        x[0] = a; x[1] = b; x[2] = c; x[3] = d; x[4] = e; x[5] = f;
        return x;
    endfunction

    // Drive ncols columns of one line, gap idle cycles after each; queue expected outputs.
    task automatic drive_line(input line_t top, input line_t mid, input line_t bot,
                              input exp_line_t expv, input int gap, input int ncols);
        exp_t e;
        for (int c = 0; c < ncols; c++) begin
            @(negedge clk);
            bus.we      = 1'b1;
            bus.pix_top = top[c];
            bus.pix_mid = mid[c];
            bus.pix_bot = bot[c];
            if (c >= 2) begin
                e.d   = map_exp(expv[c-2]);
                e.eol = (c == W - 1);
                e.eof = (c == W - 1) && (line_idx == H - 3);
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.we = 1'b0;
            end
        end
        if (ncols == W) line_idx = (line_idx + 1) % (H - 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.we = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(bus.dout_valid), 0);
        check({tag, "_dout"},  int'(bus.dout), 0);
        check({tag, "_eol"},   int'(bus.dout_eol), 0);
        check({tag, "_eof"},   int'(bus.dout_eof), 0);
    endtask

    // Monitor: pop and compare whenever the DUT presents an output.
    always @(negedge clk) begin
        exp_t e;
        if (bus.dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("dout",    int'(bus.dout), int'(e.d));
                check("eol",     int'(bus.dout_eol), int'(e.eol));
                check("eof",     int'(bus.dout_eof), int'(e.eof));
                check("latency", cyc - e.cyc, 3);
            end
        end else if (rst_p === 1'b0) begin
            check("idle_flags", int'({bus.dout_eol, bus.dout_eof}), 0);
        end
    end

    initial begin
        rst_p       = 1'b1;
        bus.we      = 1'b0;
        bus.pix_top = '0;
        bus.pix_mid = '0;
        bus.pix_bot = '0;
        bus.thresh  = 8'd128;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_p = 1'b0;

        // Flat frame: no gradient anywhere.
        for (int l = 0; l < 3; l++)
            drive_line(fill(100), fill(100), fill(100), e6(0, 0, 0, 0, 0, 0), 0, W);

        // Vertical step 0 -> 255: Gx = 1020 saturates across the edge.
        for (int l = 0; l < 3; l++)
            drive_line(step(0, 255), step(0, 255), step(0, 255), e6(0, 0, 255, 255, 0, 0), 0, W);

        // Horizontal steps: Gy = 1020, +40, -80.
        drive_line(fill(0),  fill(255), fill(255), e6(255, 255, 255, 255, 255, 255), 0, W);
        drive_line(fill(10), fill(10),  fill(20),  e6(40, 40, 40, 40, 40, 40), 0, W);
        drive_line(fill(30), fill(20),  fill(10),  e6(80, 80, 80, 80, 80, 80), 0, W);

        // Impulses: mid row (Gx only) and bottom row (Gx and Gy summed).
        drive_line(fill(0), imp(3, 200), fill(0), e6(0, 255, 0, 255, 0, 0), 0, W);
        drive_line(fill(0), imp(3, 20),  fill(0), e6(0, 40, 0, 40, 0, 0), 0, W);
        drive_line(fill(0), fill(0), imp(3, 20),  e6(0, 40, 40, 40, 0, 0), 0, W);

        // Saturation boundary: 256 -> 255, 254 passes, 128 at threshold.
        drive_line(step(0, 64), step(0, 64), step(0, 64), e6(0, 0, 255, 255, 0, 0), 0, W);
        drive_line(step(0, 63), step(0, 64), step(0, 63), e6(0, 0, 254, 254, 0, 0), 0, W);
        drive_line(step(0, 32), step(0, 32), step(0, 32), e6(0, 0, 128, 128, 0, 0), 0, W);

        // we toggling every cycle: same data, bubbles between outputs.
        for (int l = 0; l < 3; l++)
            drive_line(step(0, 255), step(0, 255), step(0, 255), e6(0, 0, 255, 255, 0, 0), 1, W);

        // Mid-line reset after column 4: in-flight results dropped, counters restart.
        idle(4);
        drive_line(step(0, 255), step(0, 255), step(0, 255), e6(0, 0, 255, 255, 0, 0), 0, 5);
        @(negedge clk);
        bus.we = 1'b0;
        rst_p  = 1'b1;
        sb.delete();
        @(negedge clk);
        check_all_zero("midreset");
        rst_p    = 1'b0;
        line_idx = 0;
        for (int l = 0; l < 3; l++)
            drive_line(step(0, 255), step(0, 255), step(0, 255), e6(0, 0, 255, 255, 0, 0), 0, W);
        idle(1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
